// File: rtl/ram_loader.sv
// ram_loader: boot-time loader that fills a contiguous region of the data RAM
// from a byte stream (SD/SPI or UART receiver). Bytes are paired big-endian
// into 16-bit words and written through the RAM write port.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start               one-cycle pulse; begins a load (ignored while busy)
//   base, count         first word address / number of words, sampled on start
//   rx_data, rx_valid   received byte and its one-cycle strobe
//   ram_address, ram_in RAM write address / data (hold when ram_load=0)
//   ram_load            RAM write enable, one pulse per word
//   busy                load in progress (holds the CPU in reset)
//   done, error         sticky outcome flags, cleared by the next accepted start
//   words               words written in the current/last load
module ram_loader #(
    parameter int DEPTH   = 3840,
    parameter int TIMEOUT = 25000000,
    parameter int TO_W    = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] base,
    input  logic [11:0] count,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] ram_address,
    output logic [15:0] ram_in,
    output logic        ram_load,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [11:0] words
);

    localparam logic [15:0]     DEPTH_W = 16'(DEPTH);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, FINISH} state_t;

    state_t          state, state_nx;
    logic [15:0]     base_q;
    logic [11:0]     count_q;
    logic [7:0]      hi_q;
    logic [TO_W-1:0] tcnt;

    logic [15:0] addr_nx;
    logic        in_range;
    logic        last;
    logic        expire;

    // Next-state logic plus the shared decode the datapath also uses.
    always_comb begin
        state_nx = state;
        addr_nx  = base_q + {4'b0, words};
        in_range = addr_nx < DEPTH_W;
        last     = (words + 12'd1) == count_q;
        // A byte on the expiry cycle wins over the abort.
        expire   = (tcnt == TO_LAST) && !rx_valid;
        case (state)
            IDLE:    if (start) state_nx = (count == 12'd0) ? FINISH : HIGH;
            HIGH:    if (rx_valid)    state_nx = LOW;
                     else if (expire) state_nx = IDLE;
            LOW:     if (rx_valid)    state_nx = !in_range ? IDLE : (last ? FINISH : HIGH);
                     else if (expire) state_nx = IDLE;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            count_q     <= '0;
            hi_q        <= '0;
            tcnt        <= '0;
            ram_address <= '0;
            ram_in      <= '0;
            ram_load    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            words       <= '0;
        end else begin
            ram_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q  <= base;
                        count_q <= count;
                        done    <= 1'b0;
                        error   <= 1'b0;
                        words   <= '0;
                        tcnt    <= '0;
                        busy    <= 1'b1;
                    end
                end
                HIGH, LOW: begin
                    if (rx_valid) begin
                        tcnt <= '0;
                        if (state == HIGH) begin
                            hi_q <= rx_data;
                        end else if (in_range) begin
                            ram_load    <= 1'b1;
                            ram_address <= addr_nx;
                            ram_in      <= {hi_q, rx_data};
                            words       <= words + 12'd1;
                        end else begin
                            // Region ran past the end of RAM: abort without writing.
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else if (expire) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        hi_q  <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                FINISH: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Boot-time loader directly upstream of the 3840-word data RAM.
- Accepts a byte stream from the SD/SPI or UART receiver and assembles big-endian 16-bit words.
- Drives the RAM write port (address, data, load) to fill a contiguous region.
- `busy` holds the Hack CPU in reset until the load ends; `done` or `error` reports the outcome.

Parameters:
- DEPTH, 3840: number of valid RAM words; writes at address >= DEPTH are illegal.
- TIMEOUT, 25000000: maximum idle cycles between bytes while loading before abort.
- TO_W, 25: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load; ignored while busy
- base  in  16  first RAM word address; sampled on accepted start
- count  in  12  number of words to load; sampled on accepted start
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data valid
- ram_address  out  16  RAM write address
- ram_in  out  16  RAM write data
- ram_load  out  1  RAM write enable, one-cycle pulse per word
- busy  out  1  load in progress; CPU hold
- done  out  1  sticky; load completed; cleared on next accepted start
- error  out  1  sticky; load aborted; cleared on next accepted start
- words  out  12  words written in current/last load

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, all counters and byte registers cleared. Reset mid-load aborts immediately; no further ram_load until a new start.
- States: IDLE, HIGH (await high byte), LOW (await low byte), FINISH.
- IDLE:
  - On start: latch base and count; clear done, error, words and the timeout counter; busy=1 next cycle.
  - If count=0: go to FINISH. Otherwise go to HIGH.
  - rx_valid in the same cycle as start is ignored.
- HIGH: on rx_valid, store rx_data as the high byte; go to LOW.
- LOW: on rx_valid, form word = {high byte, rx_data} and address = base + words (16-bit add, no wrap check beyond DEPTH).
  - If address < DEPTH: next cycle ram_load=1, ram_address=address, ram_in=word, words increments. Go to FINISH if this was word count-1, else HIGH.
  - If address >= DEPTH: no ram_load; error=1, busy=0, go to IDLE.
- Write latency: ram_load asserts exactly 1 cycle after the low-byte strobe, for exactly 1 cycle.
- rx_valid may assert every cycle; no byte is dropped in HIGH/LOW, including a byte arriving in the ram_load cycle.
- ram_address and ram_in hold their last values when ram_load=0.
- FINISH: lasts one cycle; it coincides with the final ram_load pulse, or is the cycle after start when count=0. busy=0 and done=1 from the following cycle; return to IDLE. rx_valid in FINISH and IDLE is ignored.
- Timeout:
  - Counter cleared on accepted start and on every accepted byte; increments each cycle in HIGH/LOW.
  - On reaching TIMEOUT-1 with no byte: error=1, busy=0, partial high byte discarded, go to IDLE.
  - A byte arriving on the expiry cycle is accepted and the abort does not occur.
- start while busy=1: ignored, with no change to latched base/count.
- done and error are never both 1.

Test Plan:
- base=0, count=2, bytes 0x12,0x34,0xAB,0xCD on consecutive cycles -> ram_load at addr 0 data 0x1234 and addr 1 data 0xABCD, one cycle after each low byte; busy falls and done=1 the cycle after the second pulse; words=2, error=0.
- start with count=0 -> no ram_load; done=1 two cycles after start; busy high for exactly one cycle.
- TIMEOUT=16 in bench; start, count=4, send one byte then silence -> error=1, busy=0 after 16 idle cycles; no ram_load; a new start clears error.
- base=3839, count=2, four bytes -> one write at 3839; second word gives no ram_load, error=1, words=1.
- rst_n pulsed low after 3 bytes of count=4 -> all outputs 0 asynchronously; further rx_valid bytes without start produce no ram_load.
- start reasserted with base=100 mid-load of base=0, count=3 -> ignored; all three writes go to addresses 0..2.
